dmul_lfsr_seq: RTL and testbench

DMUL_LFSR_SEQ -- requirements
Module: dmul_lfsr_seq

---
 rtl/dmul_pkg.sv | 42 ++++
 rtl/lfsr.sv | 30 +++
 rtl/dmul_lfsr_seq.sv | 126 ++++++++++++
 tb/tb_dmul_lfsr_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmul_pkg.sv
// Shared types and helpers for the LFSR-driven stochastic multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dmulState;

  localparam logic MODE_UNI = 1'b0;
  localparam logic MODE_BI  = 1'b1;

  // Width needed to hold a ones count in 0..len.
  function automatic int cntWidth(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

  // Fibonacci feedback masks for maximal-length sequences (bit i = tap i+1).
  function automatic logic [31:0] lfsrTaps(input int width);
    case (width)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous seed load; never reaches zero from a nonzero seed.
// Latency: next state one cycle after advance/load.
// Backpressure: none; holds its value while advance is low.
module lfsr
  import dmul_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsrTaps(WIDTH));

  // Seed on reset or load, otherwise shift in the tap parity when advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/dmul_lfsr_seq.sv
// Stochastic multiplier: compares operands against two LFSRs for LEN cycles and counts AND/XNOR ones.
// Latency: done pulses LEN+1 cycles after the start-accepting edge; oC holds until the next start.
// Backpressure: start is only accepted in IDLE and ignored while busy or done. Macro DMUL_ROT_EN holds LFSR-B one cycle whenever LFSR-A returns to its seed.
module dmul_lfsr_seq
  import dmul_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               LEN    = 2**WIDTH - 1,
  parameter logic [WIDTH-1:0] SEED_A = WIDTH'(1),
  parameter logic [WIDTH-1:0] SEED_B = WIDTH'(8'h5A),
  localparam int              CNT_W  = cntWidth(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] oC
);

  dmulState         fsmState;
  logic [WIDTH-1:0] aBuf;
  logic [WIDTH-1:0] bBuf;
  logic             modeBuf;
  logic [CNT_W-1:0] lenCnt;
  logic [WIDTH-1:0] lfsrA;
  logic [WIDTH-1:0] lfsrB;
  logic             seedLoad;
  logic             advA;
  logic             advB;
  logic             holdB;
  logic             bitA;
  logic             bitB;
  logic             bitC;
  logic             lastCycle;

  // Stream bit generation and LFSR stepping controls.
  always_comb begin
    seedLoad = (fsmState == IDLE) && start;
    advA     = (fsmState == RUN);
`ifdef DMUL_ROT_EN
    // Skip one B step each time A wraps back to its seed (not on the very first cycle).
    holdB    = (lfsrA == SEED_A) && (lenCnt != '0);
`else
    holdB    = 1'b0;
`endif
    advB      = advA && !holdB;
    bitA      = aBuf > lfsrA;
    bitB      = bBuf > lfsrB;
    bitC      = (modeBuf == MODE_BI) ? ~(bitA ^ bitB) : (bitA & bitB);
    lastCycle = (lenCnt == CNT_W'(LEN - 1));
  end

  lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED_A)
  ) uLfsrA (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seedLoad),
    .advance (advA),
    .state   (lfsrA)
  );

  lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED_B)
  ) uLfsrB (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seedLoad),
    .advance (advB),
    .state   (lfsrB)
  );

  // Control FSM with registered busy/done, operand latching and ones counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsmState <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      oC       <= '0;
      aBuf     <= '0;
      bBuf     <= '0;
      modeBuf  <= MODE_UNI;
      lenCnt   <= '0;
    end else begin
      case (fsmState)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            aBuf     <= iA;
            bBuf     <= iB;
            modeBuf  <= mode;
            oC       <= '0;
            lenCnt   <= '0;
            busy     <= 1'b1;
            fsmState <= RUN;
          end
        end
        RUN: begin
          oC     <= oC + CNT_W'(bitC);
          lenCnt <= lenCnt + 1'b1;
          if (lastCycle) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            fsmState <= DONE;
          end
        end
        DONE: begin
          done     <= 1'b0;
          fsmState <= IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          fsmState <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmul_lfsr_seq.sv
// Self-checking bench for dmul_lfsr_seq: fixed vector table, randomized operands
// against a sequence-table reference model, and hand-written handshake/reset sequences.
module tb_dmul_lfsr_seq;

  localparam int         WIDTH  = 8;
  localparam int         LEN    = 255;
  localparam int         PERIOD = 255;
  localparam logic [7:0] SEED_A = 8'h01;
  localparam logic [7:0] SEED_B = 8'h5A;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       mode  = 1'b0;
  logic [7:0] iA    = '0;
  logic [7:0] iB    = '0;
  logic       busy;
  logic       done;
  logic [7:0] oC;

  dmul_lfsr_seq #(
    .WIDTH  (WIDTH),
    .LEN    (LEN),
    .SEED_A (SEED_A),
    .SEED_B (SEED_B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .iA    (iA),
    .iB    (iB),
    .busy  (busy),
    .done  (done),
    .oC    (oC)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;

  // Full period of the x^8+x^6+x^5+x^4+1 sequence, and where each value sits in it.
  logic [7:0] ring [PERIOD];
  int         posOf [256];

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    int         expC;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] polyStep(input logic [7:0] s);
    int par;
    par = $countones(s & 8'hB8) % 2;
    return {s[6:0], par[0]};
  endfunction

  // Reference: walk both sequences through the ring and count ones of the combined stream.
  function automatic int model(input logic m, input logic [7:0] a, input logic [7:0] b);
    int   ia, ib, cnt;
    logic ba, bb;
    logic [7:0] la, lb;
    ia  = posOf[SEED_A];
    ib  = posOf[SEED_B];
    cnt = 0;
    for (int k = 0; k < LEN; k++) begin
      la = ring[ia];
      lb = ring[ib];
      ba = a > la;
      bb = b > lb;
      if (m ? (ba == bb) : (ba && bb)) cnt++;
      ia = (ia + 1) % PERIOD;
`ifdef DMUL_ROT_EN
      if (!(la == SEED_A && k != 0))
`endif
        ib = (ib + 1) % PERIOD;
    end
    return cnt;
  endfunction

  // One operation. pokeAt: cycle at which a stray start with other operands is pulsed.
  // rstAt: cycle at which reset is asserted mid-run. relRst: release reset together with start.
  task automatic runOp(input logic m, input logic [7:0] a, input logic [7:0] b,
                       input int pokeAt, input int rstAt, input bit relRst,
                       output int cDone, output int cBusy, output int res);
    @(negedge clk);
    if (relRst) rst_n = 1'b1;
    start = 1'b1; mode = m; iA = a; iB = b;
    @(posedge clk);
    cDone = 0; cBusy = 0; res = -1;
    for (int k = 1; k <= LEN + 20 && cDone == 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) cBusy++;
      if (done) begin
        cDone = k;
        res   = oC;
      end
      if (k == 1 && relRst) chk("busy_first_edge_after_reset", busy, 1);
      if (k == pokeAt) begin
        start = 1'b1; mode = ~m; iA = 8'd3; iB = 8'd7;
      end
      if (k == pokeAt + 1) start = 1'b0;
      if (k == rstAt) begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_abort_busy", busy, 0);
        chk("reset_abort_done", done, 0);
        chk("reset_abort_oC", oC, 0);
        cDone = -1;
      end
    end
  endtask

  task automatic checkOp(input string tag, input logic m, input logic [7:0] a,
                         input logic [7:0] b, input int expC);
    int cDone, cBusy, res;
    runOp(m, a, b, 0, 0, 1'b0, cDone, cBusy, res);
    chk({tag, "_done_cycle"}, cDone, LEN + 1);
    chk({tag, "_busy_cycles"}, cBusy, LEN);
    chk({tag, "_oC"}, res, expC);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_oC_held"}, oC, expC);
  endtask

  bit   busyH [0:600];
  bit   doneH [0:600];
  int   ocH   [0:600];

  initial begin
    int cDone, cBusy, res, cleanRes, seen, firstDone, secondDone, expC;
    logic       rm;
    logic [7:0] ra, rb;
    logic [7:0] s;

    for (int i = 0; i < 256; i++) posOf[i] = -1;
    s = 8'h01;
    for (int i = 0; i < PERIOD; i++) begin
      ring[i] = s;
      posOf[s] = i;
      s = polyStep(s);
    end

    vecs[0] = '{1'b0, 8'd0,   8'd200, 0};
    vecs[1] = '{1'b0, 8'd255, 8'd255, 253};
    vecs[2] = '{1'b1, 8'd0,   8'd0,   255};
    vecs[3] = '{1'b1, 8'd255, 8'd0,   1};
    vecs[4] = '{1'b0, 8'd255, 8'd0,   0};
    vecs[5] = '{1'b1, 8'd255, 8'd255, 253};
    vecs[6] = '{1'b0, 8'd1,   8'd255, 0};
    vecs[7] = '{1'b1, 8'd1,   8'd1,   255};

    // Reset state.
    #3 rst_n = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_oC", oC, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fixed vector table.
    for (int i = 0; i < 8; i++) begin
      checkOp($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].expC);
    end

    // Randomized operands against the reference model.
    for (int i = 0; i < 10; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      checkOp($sformatf("rand%0d", i), rm, ra, rb, model(rm, ra, rb));
    end

    // Stray start in RUN with different operands is ignored.
    runOp(1'b0, 8'd100, 8'd150, 10, 0, 1'b0, cDone, cBusy, res);
    chk("ignore_start_done_cycle", cDone, LEN + 1);
    chk("ignore_start_busy_cycles", cBusy, LEN);
    chk("ignore_start_oC", res, model(1'b0, 8'd100, 8'd150));
    @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse; a fresh run matches a clean one.
    checkOp("clean_ref", 1'b1, 8'd77, 8'd201, model(1'b1, 8'd77, 8'd201));
    runOp(1'b1, 8'd77, 8'd201, 0, 100, 1'b0, cDone, cBusy, cleanRes);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    runOp(1'b1, 8'd77, 8'd201, 0, 0, 1'b0, cDone, cBusy, res);
    chk("after_abort_done_cycle", cDone, LEN + 1);
    chk("after_abort_oC", res, model(1'b1, 8'd77, 8'd201));
    @(negedge clk);

    // start held high: back-to-back runs with exactly one IDLE cycle between them.
    start = 1'b1; mode = 1'b0; iA = 8'd180; iB = 8'd90;
    @(posedge clk);
    for (int k = 1; k <= 520; k++) begin
      @(negedge clk);
      busyH[k] = busy;
      doneH[k] = done;
      ocH[k]   = oC;
    end
    start = 1'b0;
    firstDone = 0; secondDone = 0;
    for (int k = 1; k <= 520; k++) begin
      if (doneH[k] && firstDone == 0) firstDone = k;
      else if (doneH[k] && secondDone == 0) secondDone = k;
    end
    expC = model(1'b0, 8'd180, 8'd90);
    chk("held_first_done", firstDone, LEN + 1);
    chk("held_first_oC", ocH[LEN + 1], expC);
    chk("held_idle_busy", busyH[LEN + 2], 0);
    chk("held_idle_done", doneH[LEN + 2], 0);
    chk("held_restart_busy", busyH[LEN + 3], 1);
    chk("held_second_done", secondDone, 2 * LEN + 3);
    chk("held_second_oC", ocH[2 * LEN + 3], expC);

    // Reset, then start on the first rising edge after release.
    #2 rst_n = 1'b0;
    #1;
    chk("reset2_busy", busy, 0);
    chk("reset2_oC", oC, 0);
    runOp(1'b1, 8'd33, 8'd250, 0, 0, 1'b1, cDone, cBusy, res);
    chk("first_edge_done_cycle", cDone, LEN + 1);
    chk("first_edge_oC", res, model(1'b1, 8'd33, 8'd250));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
